// File: rtl/display_pkg.sv
// Shared types and segment constants for the seven-segment display driver.
// Segment patterns are active-low: bit k drives segment k, 0 lights it.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LOAD
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

endpackage

// File: rtl/hex_digit_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles decode to a blank digit.
module hex_digit_decode
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      for (int unsigned k = 0; k < 10; k++) begin
         if (i_nibble == 4'(k)) o_seg = SEG_DIGIT[k];
      end
   end

endmodule

// File: rtl/hex_display_driver.sv
// Binary-to-decimal HEX display driver: serial double-dabble conversion,
// leading-zero blanking, overflow dashes and a free-running blink.
module hex_display_driver
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [VALUE_W-1:0]      in_value,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   output logic                    busy,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] hex
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int HEX_W = 7 * NUM_DIGITS;
   localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
   localparam int BLK_W = $clog2(BLINK_DIV);

   function automatic logic [31:0] max_display(input int unsigned n);
      logic [31:0] p;
      p = 32'd1;
      for (int unsigned k = 0; k < n; k++) p = p * 32'd10;
      return p - 32'd1;
   endfunction

   localparam logic [31:0]      MAX_VAL    = max_display(NUM_DIGITS);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(VALUE_W - 1);
   localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

   state_t               r_state, w_state_next;
   logic                 r_ready, r_busy, r_ovf, r_ovf_out, r_blank, r_phase;
   logic [VALUE_W-1:0]   r_bin;
   logic [BCD_W-1:0]     r_bcd, w_bcd_adj;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [BLK_W-1:0]     r_blink_cnt;
   logic [HEX_W-1:0]     r_disp, w_image, w_decoded;
   logic [NUM_DIGITS-1:0] w_lead_zero;
   logic                 w_value_ovf;

   assign w_value_ovf = 32'(in_value) > MAX_VAL;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_state_next = CONV;
         CONV:    if (r_bit_cnt == LAST_BIT) w_state_next = LOAD;
         LOAD:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
   end

   always_comb begin
      logic w_upper_zero;
      w_upper_zero = 1'b1;
      w_lead_zero  = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         w_upper_zero = w_upper_zero && (r_bcd[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
         w_lead_zero[NUM_DIGITS-1-k] = w_upper_zero;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      hex_digit_decode u_dec (
         .i_nibble (r_bcd[4*g +: 4]),
         .o_seg    (w_decoded[7*g +: 7])
      );
   end

   always_comb begin
      w_image = w_decoded;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (r_ovf)
            w_image[7*k +: 7] = SEG_DASH;
         else if (r_blank && (k != 0) && w_lead_zero[k])
            w_image[7*k +: 7] = SEG_BLANK;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_ovf     <= 1'b0;
         r_ovf_out <= 1'b0;
         r_blank   <= 1'b0;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_bit_cnt <= '0;
         r_disp    <= '1;
      end else begin
         r_state <= w_state_next;
         r_ready <= (w_state_next == IDLE);
         r_busy  <= (w_state_next != IDLE);
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_bin     <= in_value;
                  r_blank   <= blank_lz;
                  r_ovf     <= w_value_ovf;
                  r_bcd     <= '0;
                  r_bit_cnt <= '0;
               end
            end
            CONV: begin
               r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
               r_bin     <= r_bin << 1;
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               // A bit leaving the top nibble implies value >= 10^NUM_DIGITS,
               // already flagged at accept, so folding it in changes nothing.
               r_ovf     <= r_ovf | w_bcd_adj[BCD_W-1];
            end
            LOAD: begin
               r_disp    <= w_image;
               r_ovf_out <= r_ovf;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
   end

   assign in_ready = r_ready;
   assign busy     = r_busy;
   assign overflow = r_ovf_out;
   assign hex      = (blink_en && r_phase) ? '1 : r_disp;

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver with a decimal-arithmetic
// reference model compared every cycle, plus literal display checks.
module tb_hex_display_driver;

   localparam int ND = 4;
   localparam int VW = 14;
   localparam int BD = 4;
   localparam int HW = 7 * ND;

   localparam logic [HW-1:0] ALL1  = {HW{1'b1}};
   localparam logic [HW-1:0] H1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
   localparam logic [HW-1:0] H7B   = {21'h1FFFFF, 7'b1111000};
   localparam logic [HW-1:0] H0B   = {21'h1FFFFF, 7'b1000000};
   localparam logic [HW-1:0] HDASH = {4{7'b0111111}};
   localparam logic [HW-1:0] H9999 = {4{7'b0010000}};
   localparam logic [HW-1:0] H42B  = {14'h3FFF, 7'b0011001, 7'b0100100};

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [VW-1:0] in_value = '0;
   logic          blank_lz = 1'b0;
   logic          blink_en = 1'b0;
   logic          in_ready, busy, overflow;
   logic [HW-1:0] hex;

   always #5 clk = ~clk;

   hex_display_driver #(
      .NUM_DIGITS (ND),
      .VALUE_W    (VW),
      .BLINK_DIV  (BD)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_value (in_value),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .busy     (busy),
      .overflow (overflow),
      .hex      (hex)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   logic [6:0] seg_tab [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [HW-1:0] image(input int v, input bit bl);
      logic [HW-1:0] r;
      int p;
      if (v > 9999) return HDASH;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         if (bl && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
         else                      r[7*i +: 7] = seg_tab[(v / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   // Reference model: cycles left until the result appears, cycles since reset
   int            m_left = 0;
   int            m_cyc  = 0;
   int            m_val  = 0;
   bit            m_bl   = 0;
   bit            m_ovf  = 0;
   bit            m_init = 0;
   logic [HW-1:0] m_disp = '1;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_left = 0;
         m_cyc  = 0;
         m_disp = '1;
         m_ovf  = 0;
         m_init = 1;
      end else if (m_init) begin
         m_cyc++;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_disp = image(m_val, m_bl);
               m_ovf  = (m_val > 9999);
            end
         end else if (in_valid) begin
            m_val  = int'(in_value);
            m_bl   = blank_lz;
            m_left = VW + 1;
         end
      end
   end

   always @(negedge clk) begin
      logic [HW-1:0] e_hex;
      if (m_init) begin
         e_hex = (blink_en && ((m_cyc / BD) % 2 == 1)) ? ALL1 : m_disp;
         check("busy", busy, 32'(m_left > 0));
         check("in_ready", in_ready, 32'(m_left == 0));
         check("overflow", overflow, 32'(m_ovf));
         check("hex", hex, e_hex);
      end
   end

   task automatic send(input int v, input bit b);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got in_ready=0 expected 1 at %0t", $time);
      end
      in_valid = 1'b1;
      in_value = VW'(v);
      blank_lz = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      repeat (VW + 1) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hex", hex, ALL1);
      check("reset_busy", busy, 0);
      check("reset_ready", in_ready, 1);
      reset_n = 1'b1;

      send(1234, 0); wait_done();
      check("lit_1234", hex, H1234);
      check("lit_1234_ovf", overflow, 0);

      send(7, 1); wait_done();
      check("lit_7_blank", hex, H7B);

      send(0, 1); wait_done();
      check("lit_0_blank", hex, H0B);

      send(12000, 0); wait_done();
      check("lit_dash", hex, HDASH);
      check("lit_dash_ovf", overflow, 1);

      send(9999, 0); wait_done();
      check("lit_9999", hex, H9999);
      check("lit_9999_ovf", overflow, 0);

      send(1234, 0);
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_value = VW'(55);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("ignore_ready", in_ready, 0);
      repeat (10) @(posedge clk);
      #1;
      check("ignore_1234", hex, H1234);

      send(9999, 0);
      repeat (7) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("abort_hex", hex, ALL1);
      check("abort_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      send(42, 1); wait_done();
      check("lit_42_blank", hex, H42B);

      send(1234, 0); wait_done();
      blink_en = 1'b1;
      g = 0;
      while (hex !== ALL1 && g < 12) begin
         @(posedge clk); #1;
         g++;
      end
      check("blink_blank", hex, ALL1);
      @(posedge clk); #1;
      blink_en = 1'b0;
      #1;
      check("blink_clear", hex, H1234);
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
